// File: rtl/pos_pkg.sv
// Shared constants for the board position encoder/decoder pair.
package pos_pkg;

  localparam int unsigned POS_W       = 4;
  localparam int unsigned DEF_NUM_POS = 9;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    VALID    = 2'd1,
    WAIT_REL = 2'd2
  } pos_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus whole-vector debounce producing the accepted button vector.
// Build option: POSITION_ENCODER_DEBOUNCE_EN adds the DB_CYCLES stability counter.
module btn_debounce #(
  parameter int unsigned NUM_POS = 9
`ifdef POSITION_ENCODER_DEBOUNCE_EN
  ,
  parameter int unsigned DB_CYCLES = 16
`endif
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic [NUM_POS-1:0] i_btn,
  output logic [NUM_POS-1:0] o_db_vec
);

  logic [NUM_POS-1:0] r_sync1;
  logic [NUM_POS-1:0] r_sync2;
  logic [NUM_POS-1:0] r_db;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

`ifdef POSITION_ENCODER_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  // r_sync1 != r_sync2 means sync_vec changes on this edge, so the count restarts with it.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
      r_db  <= '0;
    end else if ((r_sync1 != r_sync2) || (r_sync2 == r_db)) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_W'(DB_CYCLES)) begin
      r_cnt <= '0;
      r_db  <= r_sync2;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
`else
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_db <= '0;
    end else begin
      r_db <= r_sync2;
    end
  end
`endif

  assign o_db_vec = r_db;

endmodule

// File: rtl/position_encoder.sv
// Board cell buttons to 4-bit position code with valid/ack handshake and multi-press reject.
// Build option: POSITION_ENCODER_DEBOUNCE_EN enables the DB_CYCLES debounce counter.
module position_encoder
  import pos_pkg::*;
#(
  parameter int unsigned NUM_POS = DEF_NUM_POS
`ifdef POSITION_ENCODER_DEBOUNCE_EN
  ,
  parameter int unsigned DB_CYCLES = 16
`endif
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_POS-1:0] btn_in,
  input  logic               pos_ack,
  output logic [POS_W-1:0]   pos_out,
  output logic               pos_valid,
  output logic               multi_err,
  output logic               busy
);

  logic [NUM_POS-1:0] w_db_vec;
  logic [POS_W:0]     w_ones;
  logic [POS_W-1:0]   w_idx;
  logic               w_any;
  logic               w_one;

  pos_state_e       r_state;
  pos_state_e       w_state_next;
  logic [POS_W-1:0] r_pos_out;
  logic [POS_W-1:0] w_pos_out_next;
  logic             r_pos_valid;
  logic             w_pos_valid_next;
  logic             r_multi_err;
  logic             w_multi_err_next;

  btn_debounce #(
    .NUM_POS  (NUM_POS)
`ifdef POSITION_ENCODER_DEBOUNCE_EN
    ,
    .DB_CYCLES(DB_CYCLES)
`endif
  ) u_btn_debounce (
    .i_clock  (clock),
    .i_reset_n(reset_n),
    .i_btn    (btn_in),
    .o_db_vec (w_db_vec)
  );

  // w_idx is only meaningful when exactly one bit is set.
  always_comb begin
    w_ones = '0;
    w_idx  = '0;
    for (int unsigned i = 0; i < NUM_POS; i++) begin
      if (w_db_vec[i]) begin
        w_ones = w_ones + (POS_W + 1)'(1);
        w_idx  = POS_W'(i);
      end
    end
  end

  assign w_any = |w_db_vec;
  assign w_one = (w_ones == (POS_W + 1)'(1));

  always_comb begin
    w_state_next     = r_state;
    w_pos_out_next   = r_pos_out;
    w_pos_valid_next = r_pos_valid;
    w_multi_err_next = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_one) begin
          w_pos_out_next   = w_idx;
          w_pos_valid_next = 1'b1;
          w_state_next     = VALID;
        end else if (w_any) begin
          w_multi_err_next = 1'b1;
          w_state_next     = WAIT_REL;
        end
      end
      VALID: begin
        if (pos_ack) begin
          w_pos_valid_next = 1'b0;
          w_state_next     = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (!w_any) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_pos_valid_next = 1'b0;
        w_state_next     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_pos_out   <= '0;
      r_pos_valid <= 1'b0;
      r_multi_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pos_out   <= w_pos_out_next;
      r_pos_valid <= w_pos_valid_next;
      r_multi_err <= w_multi_err_next;
    end
  end

  assign pos_out   = r_pos_out;
  assign pos_valid = r_pos_valid;
  assign multi_err = r_multi_err;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_position_encoder.sv
// Directed-vector bench for position_encoder; latency follows POSITION_ENCODER_DEBOUNCE_EN.
module tb_position_encoder;

`ifdef POSITION_ENCODER_DEBOUNCE_EN
  localparam int LAT = 16 + 3;
`else
  localparam int LAT = 3;
`endif

  logic       clock = 1'b0;
  logic       reset_n;
  logic [8:0] btn_in;
  logic       pos_ack;
  logic [3:0] pos_out;
  logic       pos_valid;
  logic       multi_err;
  logic       busy;

  int   checks       = 0;
  int   errors       = 0;
  int   valid_rises  = 0;
  int   multi_cycles = 0;
  logic valid_prev   = 1'b0;

  position_encoder #(
    .NUM_POS(9)
  ) u_dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .btn_in   (btn_in),
    .pos_ack  (pos_ack),
    .pos_out  (pos_out),
    .pos_valid(pos_valid),
    .multi_err(multi_err),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (pos_valid && !valid_prev) valid_rises++;
    valid_prev = pos_valid;
    if (multi_err) multi_cycles++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < LAT + 20; i++) begin
      if (!busy) break;
      tick(1);
    end
    check_eq(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < LAT + 20; i++) begin
      if (pos_valid) break;
      tick(1);
    end
    check_eq(tag, 32'(pos_valid), 32'd1);
  endtask

  // Drive a press right after an edge, then check the exact edge where valid rises.
  task automatic press_expect(input logic [8:0] b, input logic [3:0] pos, input string tag);
    btn_in = b;
    tick(LAT);
    check_eq({tag, "_early"}, 32'(pos_valid), 32'd0);
    tick(1);
    check_eq({tag, "_valid"}, 32'(pos_valid), 32'd1);
    check_eq({tag, "_pos"}, 32'(pos_out), 32'(pos));
  endtask

  task automatic ack_release(input string tag);
    pos_ack = 1'b1;
    tick(1);
    pos_ack = 1'b0;
    check_eq({tag, "_ack_clr"}, 32'(pos_valid), 32'd0);
    check_eq({tag, "_ack_busy"}, 32'(busy), 32'd1);
    btn_in = '0;
    wait_idle({tag, "_idle"});
  endtask

  initial begin
    int r0;
    int m0;
    logic bad;

    reset_n = 1'b0;
    btn_in  = 9'h010;
    pos_ack = 1'b0;
    tick(3);
    check_eq("rst_pos_out", 32'(pos_out), 32'd0);
    check_eq("rst_pos_valid", 32'(pos_valid), 32'd0);
    check_eq("rst_multi_err", 32'(multi_err), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    btn_in  = '0;
    reset_n = 1'b1;
    tick(LAT + 5);
    check_eq("idle_no_valid", 32'(pos_valid), 32'd0);

    pos_ack = 1'b1;
    tick(2);
    pos_ack = 1'b0;
    check_eq("ack_in_idle", 32'(busy), 32'd0);

    press_expect(9'h010, 4'd4, "cell4");
    tick(30);
    check_eq("cell4_hold_valid", 32'(pos_valid), 32'd1);
    check_eq("cell4_hold_pos", 32'(pos_out), 32'd4);
    ack_release("cell4");

`ifdef POSITION_ENCODER_DEBOUNCE_EN
    r0  = valid_rises;
    bad = 1'b0;
    for (int seg = 0; seg < 8; seg++) begin
      btn_in = (seg % 2 == 0) ? 9'h100 : 9'h000;
      for (int k = 0; k < 5; k++) begin
        tick(1);
        if (pos_valid) bad = 1'b1;
      end
    end
    check_eq("bounce_quiet", 32'(bad), 32'd0);
    btn_in = 9'h100;
    wait_valid("bounce_settle_valid");
    check_eq("bounce_settle_pos", 32'(pos_out), 32'd8);
    check_eq("bounce_one_rise", 32'(valid_rises - r0), 32'd1);
    pos_ack = 1'b1;
    tick(1);
    pos_ack = 1'b0;
    for (int seg = 0; seg < 6; seg++) begin
      btn_in = (seg % 2 == 0) ? 9'h000 : 9'h100;
      tick(5);
    end
    check_eq("bounce_rel_busy", 32'(busy), 32'd1);
    btn_in = '0;
    wait_idle("bounce_rel_idle");
    r0 = valid_rises;
    press_expect(9'h100, 4'd8, "repress8");
    tick(5);
    check_eq("repress_one_rise", 32'(valid_rises - r0), 32'd1);
    ack_release("repress8");
`else
    press_expect(9'h100, 4'd8, "cell8");
    ack_release("cell8");
`endif

    m0     = multi_cycles;
    btn_in = 9'h003;
    tick(LAT);
    check_eq("multi_early", 32'(multi_err), 32'd0);
    tick(1);
    check_eq("multi_pulse", 32'(multi_err), 32'd1);
    check_eq("multi_no_valid", 32'(pos_valid), 32'd0);
    check_eq("multi_busy", 32'(busy), 32'd1);
    tick(1);
    check_eq("multi_end", 32'(multi_err), 32'd0);
    tick(5);
    check_eq("multi_one_cycle", 32'(multi_cycles - m0), 32'd1);
    check_eq("multi_still_no_valid", 32'(pos_valid), 32'd0);
    btn_in = '0;
    wait_idle("multi_idle");
    press_expect(9'h001, 4'd0, "cell0");
    ack_release("cell0");

    press_expect(9'h004, 4'd2, "cell2");
    btn_in = 9'h020;
    tick(LAT + 5);
    check_eq("cell2_hold_valid", 32'(pos_valid), 32'd1);
    check_eq("cell2_hold_pos", 32'(pos_out), 32'd2);
    ack_release("cell2");
    press_expect(9'h020, 4'd5, "cell5");
    ack_release("cell5");

    pos_ack = 1'b1;
    press_expect(9'h080, 4'd7, "first_ack7");
    tick(1);
    check_eq("first_ack_drop", 32'(pos_valid), 32'd0);
    pos_ack = 1'b0;
    btn_in  = '0;
    wait_idle("first_ack_idle");

    press_expect(9'h010, 4'd4, "pre_rst");
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_valid", 32'(pos_valid), 32'd0);
    check_eq("async_rst_pos", 32'(pos_out), 32'd0);
    check_eq("async_rst_busy", 32'(busy), 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(LAT);
    check_eq("post_rst_early", 32'(pos_valid), 32'd0);
    tick(1);
    check_eq("post_rst_valid", 32'(pos_valid), 32'd1);
    check_eq("post_rst_pos", 32'(pos_out), 32'd4);
    ack_release("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
